// File: rtl/jbi_sc2_pkg.sv
// Shared types and constants for the JBI-side bank-2 request issue path.
package jbi_sc2_pkg;

    localparam int unsigned HDR_W    = 64;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned ECC_W    = 7;
    localparam int unsigned NBEATS_W = 5;

    localparam logic [NBEATS_W-1:0] NB_NONE = 5'd0;
    localparam logic [NBEATS_W-1:0] NB_8B   = 5'd2;
    localparam logic [NBEATS_W-1:0] NB_64B  = 5'd16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHdr1 = 2'd1,
        StData = 2'd2
    } state_e;

    // Anything other than the three legal payload sizes issues as a full line.
    function automatic logic [NBEATS_W-1:0] norm_nbeats(input logic [NBEATS_W-1:0] nb);
        case (nb)
            NB_NONE, NB_8B, NB_64B: return nb;
            default:                return NB_64B;
        endcase
    endfunction

endpackage

// File: rtl/jbi_sc2_req_issue_credit.sv
// Credit counter: starts full, dec on issue, inc on L2 dequeue, sticky error on overflow.
module jbi_credit_cnt #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             nonzero,
    output logic             err
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(DEPTH);

    logic [WIDTH-1:0] count_q;
    logic             err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= MAX;
            err_q   <= 1'b0;
        end else if (inc && !dec) begin
            // A return with every credit already home means the L2 side lost track.
            if (count_q == MAX) begin
                err_q <= 1'b1;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end else if (dec && !inc && count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count   = count_q;
    assign nonzero = (count_q != '0);
    assign err     = err_q;

endmodule

// File: rtl/jbi_sc2_req_issue.sv
// Serializes header + payload requests onto the 32-bit JBI-to-L2 bank-2 request bus.
module jbi_sc2_req_issue
    import jbi_sc2_pkg::*;
#(
    parameter int unsigned IQ_DEPTH  = 16,
    parameter int unsigned WIB_DEPTH = 4
) (
    input  logic                rclk,
    input  logic                rst,
    input  logic                req_vld,
    output logic                req_rdy,
    input  logic [HDR_W-1:0]    req_hdr,
    input  logic [NBEATS_W-1:0] req_nbeats,
    input  logic                req_wr,
    input  logic [WORD_W-1:0]   dat_word,
    input  logic [ECC_W-1:0]    dat_ecc,
    output logic                dat_pop,
    input  logic                sctag_jbi_iq_dequeue_d1,
    input  logic                sctag_jbi_wib_dequeue_d1,
    input  logic                sctag_jbi_por_req_d1,
    output logic [WORD_W-1:0]   jbi_sctag_req,
    output logic [ECC_W-1:0]    jbi_scbuf_ecc,
    output logic                jbi_sctag_req_vld,
    output logic                credit_err,
    output logic [4:0]          iq_credits
);

    localparam int unsigned IQ_W  = $clog2(IQ_DEPTH + 1);
    localparam int unsigned WIB_W = $clog2(WIB_DEPTH + 1);

    state_e                state_q;
    logic [WORD_W-1:0]     hdr_lo_q;
    logic [NBEATS_W-1:0]   beat_cnt_q;
    logic [WORD_W-1:0]     req_q;
    logic [ECC_W-1:0]      ecc_q;
    logic                  vld_q;

    logic [IQ_W-1:0]       iq_cnt;
    logic [WIB_W-1:0]      wib_cnt;
    logic                  iq_nz, wib_nz;
    logic                  iq_err, wib_err;
    logic                  accept;
    logic                  unused_wib_cnt;

    assign req_rdy = (state_q == StIdle) && iq_nz && (!req_wr || wib_nz) &&
                     !sctag_jbi_por_req_d1;
    assign accept  = req_vld && req_rdy;
    assign dat_pop = (state_q == StData);

    jbi_credit_cnt #(
        .DEPTH (IQ_DEPTH)
    ) u_iq_cnt (
        .clk     (rclk),
        .rst     (rst),
        .inc     (sctag_jbi_iq_dequeue_d1),
        .dec     (accept),
        .count   (iq_cnt),
        .nonzero (iq_nz),
        .err     (iq_err)
    );

    jbi_credit_cnt #(
        .DEPTH (WIB_DEPTH)
    ) u_wib_cnt (
        .clk     (rclk),
        .rst     (rst),
        .inc     (sctag_jbi_wib_dequeue_d1),
        .dec     (accept && req_wr),
        .count   (wib_cnt),
        .nonzero (wib_nz),
        .err     (wib_err)
    );

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            hdr_lo_q   <= '0;
            beat_cnt_q <= '0;
            req_q      <= '0;
            ecc_q      <= '0;
            vld_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        req_q      <= req_hdr[HDR_W-1:WORD_W];
                        ecc_q      <= '0;
                        vld_q      <= 1'b1;
                        hdr_lo_q   <= req_hdr[WORD_W-1:0];
                        beat_cnt_q <= norm_nbeats(req_nbeats);
                        state_q    <= StHdr1;
                    end else begin
                        req_q <= '0;
                        ecc_q <= '0;
                        vld_q <= 1'b0;
                    end
                end
                StHdr1: begin
                    req_q   <= hdr_lo_q;
                    ecc_q   <= '0;
                    vld_q   <= 1'b0;
                    state_q <= (beat_cnt_q != '0) ? StData : StIdle;
                end
                StData: begin
                    req_q      <= dat_word;
                    ecc_q      <= dat_ecc;
                    vld_q      <= 1'b0;
                    beat_cnt_q <= beat_cnt_q - 1'b1;
                    if (beat_cnt_q == 5'd1) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    req_q   <= '0;
                    ecc_q   <= '0;
                    vld_q   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign jbi_sctag_req     = req_q;
    assign jbi_scbuf_ecc     = ecc_q;
    assign jbi_sctag_req_vld = vld_q;
    assign credit_err        = iq_err | wib_err;
    assign iq_credits        = 5'(iq_cnt);

    // WIB occupancy is only needed as the nonzero flag here.
    assign unused_wib_cnt = ^wib_cnt;

endmodule

// File: tb/tb_jbi_sc2_req_issue.sv
// Scoreboard bench for jbi_sc2_req_issue: expected bus words queued at issue, checked on the bus.
module tb_jbi_sc2_req_issue;

    logic        rclk = 1'b0;
    logic        rst  = 1'b1;
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic [63:0] req_hdr = '0;
    logic [4:0]  req_nbeats = '0;
    logic        req_wr = 1'b0;
    logic [31:0] dat_word;
    logic [6:0]  dat_ecc;
    logic        dat_pop;
    logic        sctag_jbi_iq_dequeue_d1 = 1'b0;
    logic        sctag_jbi_wib_dequeue_d1 = 1'b0;
    logic        sctag_jbi_por_req_d1 = 1'b0;
    logic [31:0] jbi_sctag_req;
    logic [6:0]  jbi_scbuf_ecc;
    logic        jbi_sctag_req_vld;
    logic        credit_err;
    logic [4:0]  iq_credits;

    always #5 rclk = ~rclk;

    jbi_sc2_req_issue #(
        .IQ_DEPTH  (16),
        .WIB_DEPTH (4)
    ) dut (
        .rclk                     (rclk),
        .rst                      (rst),
        .req_vld                  (req_vld),
        .req_rdy                  (req_rdy),
        .req_hdr                  (req_hdr),
        .req_nbeats               (req_nbeats),
        .req_wr                   (req_wr),
        .dat_word                 (dat_word),
        .dat_ecc                  (dat_ecc),
        .dat_pop                  (dat_pop),
        .sctag_jbi_iq_dequeue_d1  (sctag_jbi_iq_dequeue_d1),
        .sctag_jbi_wib_dequeue_d1 (sctag_jbi_wib_dequeue_d1),
        .sctag_jbi_por_req_d1     (sctag_jbi_por_req_d1),
        .jbi_sctag_req            (jbi_sctag_req),
        .jbi_scbuf_ecc            (jbi_scbuf_ecc),
        .jbi_sctag_req_vld        (jbi_sctag_req_vld),
        .credit_err               (credit_err),
        .iq_credits               (iq_credits)
    );

    // Upstream payload buffer: dat_word follows a read pointer advanced by dat_pop.
    logic [31:0] pay_word [16];
    logic [6:0]  pay_ecc  [16];
    logic [4:0]  dat_idx;
    int          pop_cnt;
    int          cyc;

    assign dat_word = pay_word[dat_idx[3:0]];
    assign dat_ecc  = pay_ecc[dat_idx[3:0]];

    always @(posedge rclk or posedge rst) begin
        if (rst) begin
            dat_idx <= '0;
            pop_cnt <= 0;
        end else if (req_vld && req_rdy) begin
            dat_idx <= '0;
        end else if (dat_pop) begin
            dat_idx <= dat_idx + 5'd1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    always @(posedge rclk) cyc <= cyc + 1;

    always @(posedge rclk) begin
        if (!rst && req_vld && req_rdy)
            assert (req_nbeats == 5'd0 || req_nbeats == 5'd2 || req_nbeats == 5'd16)
            else $error("illegal req_nbeats %0d accepted", req_nbeats);
    end

    int          n_checks = 0;
    int          n_fail = 0;
    logic [39:0] exp_q [$];
    int          len_q [$];
    int          remaining = 0;
    int          iq_exp = 16;

    task automatic monitor();
        logic [39:0] exp;
        logic [39:0] got;
        forever begin
            @(negedge rclk);
            got = {jbi_sctag_req_vld, jbi_scbuf_ecc, jbi_sctag_req};
            if (rst) begin
                remaining = 0;
                exp_q.delete();
                len_q.delete();
            end else begin
                if (remaining == 0 && jbi_sctag_req_vld) begin
                    if (len_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_hdr: got %h, no packet expected", got);
                    end else begin
                        remaining = len_q.pop_front();
                    end
                end
                n_checks++;
                if (remaining > 0) begin
                    exp = exp_q.pop_front();
                    remaining--;
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL bus_word: got vld/ecc/data %h, expected %h", got, exp);
                    end
                end else if (got !== 40'd0) begin
                    n_fail++;
                    $display("FAIL idle_bus: got %h, expected 0", got);
                end
            end
        end
    endtask

    task automatic set_payload(input int seed);
        for (int i = 0; i < 16; i++) begin
            pay_word[i] = 32'(seed + i);
            pay_ecc[i]  = 7'(seed * 7 + i * 37 + 5);
        end
    endtask

    task automatic push_expected(input logic [63:0] hdr, input logic [4:0] nb);
        exp_q.push_back({1'b1, 7'd0, hdr[63:32]});
        exp_q.push_back({1'b0, 7'd0, hdr[31:0]});
        for (int i = 0; i < int'(nb); i++) exp_q.push_back({1'b0, pay_ecc[i], pay_word[i]});
        len_q.push_back(2 + int'(nb));
    endtask

    // Entered and left 1 time unit after a rising edge; returns just after the accept edge.
    task automatic issue(input logic [63:0] hdr, input logic [4:0] nb, input logic wr,
                         input logic coincide);
        int tries = 0;
        push_expected(hdr, nb);
        req_vld = 1'b1; req_hdr = hdr; req_nbeats = nb; req_wr = wr;
        #1;
        while (!req_rdy && tries < 200) begin
            @(posedge rclk); #2;
            tries++;
        end
        if (!req_rdy) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout: req_rdy=%b after %0d cycles, expected 1", req_rdy, tries);
            req_vld = 1'b0; req_wr = 1'b0;
            @(posedge rclk); #1;
            return;
        end
        sctag_jbi_iq_dequeue_d1 = coincide;
        @(posedge rclk); #1;
        req_vld = 1'b0; req_wr = 1'b0; sctag_jbi_iq_dequeue_d1 = 1'b0;
        if (!coincide) iq_exp--;
        n_checks++;
        if (iq_credits !== 5'(iq_exp)) begin
            n_fail++;
            $display("FAIL iq_after_accept: got %0d, expected %0d", iq_credits, iq_exp);
        end
    endtask

    task automatic pulse(input logic iq, input logic wib, input int n);
        for (int i = 0; i < n; i++) begin
            sctag_jbi_iq_dequeue_d1 = iq; sctag_jbi_wib_dequeue_d1 = wib;
            @(posedge rclk); #1;
            sctag_jbi_iq_dequeue_d1 = 1'b0; sctag_jbi_wib_dequeue_d1 = 1'b0;
            if (iq && iq_exp < 16) iq_exp++;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((remaining != 0 || len_q.size() != 0) && t < 100) begin
            @(posedge rclk); #1;
            t++;
        end
        n_checks++;
        if (remaining != 0 || len_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: remaining=%0d pending=%0d, expected 0/0",
                     remaining, len_q.size());
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({jbi_sctag_req_vld, jbi_scbuf_ecc, jbi_sctag_req, dat_pop, credit_err} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got vld=%b ecc=%h req=%h pop=%b err=%b, expected all 0",
                     jbi_sctag_req_vld, jbi_scbuf_ecc, jbi_sctag_req, dat_pop, credit_err);
        end
        n_checks++;
        if (iq_credits !== 5'd16) begin
            n_fail++;
            $display("FAIL reset_iq: got %0d, expected 16", iq_credits);
        end
    endtask

    task automatic test_read();
        int p0 = pop_cnt;
        issue(64'hA5A5_0000_1234_5678, 5'd0, 1'b0, 1'b0);
        drain();
        n_checks++;
        if (pop_cnt != p0) begin
            n_fail++;
            $display("FAIL read_no_pop: got %0d pops, expected 0", pop_cnt - p0);
        end
    endtask

    task automatic test_write64();
        int p0;
        set_payload(0);
        p0 = pop_cnt;
        issue(64'hDEAD_BEEF_0BAD_F00D, 5'd16, 1'b1, 1'b0);
        drain();
        n_checks++;
        if (pop_cnt - p0 != 16) begin
            n_fail++;
            $display("FAIL write_pops: got %0d, expected 16", pop_cnt - p0);
        end
        pulse(1'b1, 1'b0, 2);
        pulse(1'b0, 1'b1, 1);
        n_checks++;
        if (iq_credits !== 5'd16) begin
            n_fail++;
            $display("FAIL iq_restored: got %0d, expected 16", iq_credits);
        end
    endtask

    task automatic test_wib_credit();
        set_payload(100);
        for (int i = 0; i < 4; i++) issue(64'h5700_0000_0000_0000 + 64'(i), 5'd2, 1'b1, 1'b0);
        drain();
        req_wr = 1'b1; #1;
        n_checks++;
        if (req_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL wib_empty_write: req_rdy got %b, expected 0", req_rdy);
        end
        req_wr = 1'b0; #1;
        n_checks++;
        if (req_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL wib_empty_read: req_rdy got %b, expected 1", req_rdy);
        end
        @(posedge rclk); #1;
        pulse(1'b0, 1'b1, 1);
        req_wr = 1'b1; #1;
        n_checks++;
        if (req_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL wib_return: req_rdy got %b, expected 1", req_rdy);
        end
        req_wr = 1'b0;
        @(posedge rclk); #1;
        pulse(1'b0, 1'b1, 3);
        pulse(1'b1, 1'b0, 4);
    endtask

    task automatic test_back_to_back();
        int prev = 0;
        for (int i = 0; i < 16; i++) begin
            issue(64'hB000_0000_0000_0000 + 64'(i), 5'd0, 1'b0, 1'b0);
            if (i > 0) begin
                n_checks++;
                if (cyc - prev != 2) begin
                    n_fail++;
                    $display("FAIL b2b_gap: got %0d cycles, expected 2", cyc - prev);
                end
            end
            prev = cyc;
        end
        req_vld = 1'b1; req_hdr = 64'hC0FF_EE00_0000_0000; req_nbeats = 5'd0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (req_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL iq_exhausted: req_rdy got %b, expected 0", req_rdy);
            end
            @(posedge rclk); #1;
        end
        sctag_jbi_iq_dequeue_d1 = 1'b1;
        @(posedge rclk); #1;
        sctag_jbi_iq_dequeue_d1 = 1'b0;
        req_vld = 1'b0;
        iq_exp = 1;
        n_checks++;
        if (req_rdy !== 1'b1 || iq_credits !== 5'd1) begin
            n_fail++;
            $display("FAIL iq_one_return: req_rdy=%b iq=%0d, expected 1/1", req_rdy, iq_credits);
        end
        drain();
    endtask

    task automatic test_credit_edges();
        issue(64'hC0C0_0000_0000_0001, 5'd0, 1'b0, 1'b1);
        drain();
        pulse(1'b1, 1'b0, 15);
        n_checks++;
        if (iq_credits !== 5'd16 || credit_err !== 1'b0) begin
            n_fail++;
            $display("FAIL iq_full: iq=%0d err=%b, expected 16/0", iq_credits, credit_err);
        end
        pulse(1'b1, 1'b0, 1);
        n_checks++;
        if (iq_credits !== 5'd16 || credit_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: iq=%0d err=%b, expected 16/1", iq_credits, credit_err);
        end
        repeat (5) @(posedge rclk);
        #1;
        n_checks++;
        if (credit_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b, expected 1", credit_err);
        end
    endtask

    task automatic test_por();
        set_payload(32'h4000);
        issue(64'h9090_0000_ABCD_0000, 5'd16, 1'b1, 1'b0);
        repeat (5) @(posedge rclk);
        #1;
        sctag_jbi_por_req_d1 = 1'b1;
        push_expected(64'h7070_0000_0000_0007, 5'd0);
        req_vld = 1'b1; req_hdr = 64'h7070_0000_0000_0007; req_nbeats = 5'd0;
        for (int k = 0; k < 20; k++) begin
            n_checks++;
            if (req_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL por_block: req_rdy got %b at cycle %0d, expected 0", req_rdy, k);
            end
            @(posedge rclk); #1;
        end
        n_checks++;
        if (remaining != 0 || len_q.size() != 1 || iq_credits !== 5'(iq_exp)) begin
            n_fail++;
            $display("FAIL por_complete: remaining=%0d pending=%0d iq=%0d, expected 0/1/%0d",
                     remaining, len_q.size(), iq_credits, iq_exp);
        end
        sctag_jbi_por_req_d1 = 1'b0;
        #1;
        n_checks++;
        if (req_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL por_resume: req_rdy got %b, expected 1", req_rdy);
        end
        @(posedge rclk); #1;
        req_vld = 1'b0;
        iq_exp--;
        drain();
        pulse(1'b1, 1'b0, 2);
        pulse(1'b0, 1'b1, 1);
    endtask

    task automatic test_reset_mid();
        set_payload(32'h0100);
        issue(64'h3131_0000_0000_3131, 5'd16, 1'b1, 1'b0);
        repeat (6) @(posedge rclk);
        #1;
        n_checks++;
        if (dat_pop !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_data: dat_pop got %b, expected 1", dat_pop);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({jbi_sctag_req_vld, jbi_scbuf_ecc, jbi_sctag_req, dat_pop, credit_err} !== 42'd0 ||
            iq_credits !== 5'd16) begin
            n_fail++;
            $display("FAIL async_reset: vld=%b ecc=%h req=%h pop=%b err=%b iq=%0d, expected 0s/16",
                     jbi_sctag_req_vld, jbi_scbuf_ecc, jbi_sctag_req, dat_pop, credit_err,
                     iq_credits);
        end
        @(posedge rclk); #1;
        rst = 1'b0;
        iq_exp = 16;
        set_payload(32'h0200);
        issue(64'h6262_0000_0000_6262, 5'd2, 1'b1, 1'b0);
        drain();
    endtask

    initial begin
        fork
            monitor();
        join_none
        #12;
        test_reset();
        @(posedge rclk); #1;
        rst = 1'b0;
        test_read();
        test_write64();
        test_wib_credit();
        test_back_to_back();
        test_credit_edges();
        test_por();
        test_reset_mid();
        repeat (3) @(posedge rclk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d queued words, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jbi_sc2_req_issue.md
Name: jbi_sc2_req_issue

Overview:
Request issue stage on the JBI side of the L2 bank-2 interface; it feeds the bank-2 JBI-to-L2 flop stage directly. It accepts whole requests (64-bit header plus 0, 2 or 16 payload words) and serializes them onto the 32-bit jbi_sctag_req bus. It also drives the companion ECC and valid signals. Issue is flow-controlled by IQ and WIB credit counters, which are replenished by the flopped dequeue pulses returning from the L2 bank.

Parameters:
IQ_DEPTH, 16, L2 input-queue entries; initial and maximum IQ credits
WIB_DEPTH, 4, L2 write-invalidate-buffer entries; initial and maximum WIB credits

Ports:
rclk  in  1  clock
rst  in  1  asynchronous active-high reset
req_vld  in  1  upstream request present
req_rdy  out  1  request accepted this cycle when req_vld & req_rdy
req_hdr  in  64  request header, sampled on accept
req_nbeats  in  5  payload words: 0, 2 or 16; other values illegal
req_wr  in  1  request is a write; consumes one WIB credit
dat_word  in  32  current payload word from upstream buffer, valid combinationally
dat_ecc  in  7  ECC of dat_word
dat_pop  out  1  consumes dat_word/dat_ecc this cycle
sctag_jbi_iq_dequeue_d1  in  1  single-cycle pulse; returns one IQ credit
sctag_jbi_wib_dequeue_d1  in  1  single-cycle pulse; returns one WIB credit
sctag_jbi_por_req_d1  in  1  POR request from L2; blocks new issue while high
jbi_sctag_req  out  32  serialized request word
jbi_scbuf_ecc  out  7  ECC for payload words; 0 on header words
jbi_sctag_req_vld  out  1  high only on the first header word of a packet
credit_err  out  1  sticky flag: credit return arrived while the counter was at maximum
iq_credits  out  5  current IQ credit count, for debug

Behaviour:
- Reset (async): state IDLE; iq_cnt=IQ_DEPTH; wib_cnt=WIB_DEPTH; jbi_sctag_req=0; jbi_scbuf_ecc=0; jbi_sctag_req_vld=0; credit_err=0; dat_pop=0.
- req_rdy = (state==IDLE) & (iq_cnt!=0) & (~req_wr | wib_cnt!=0) & ~sctag_jbi_por_req_d1. Combinational, with no dependency on req_vld.
- All bus outputs are registered.
- FSM: IDLE, HDR1, DATA.
  - IDLE + accept: output regs <= {hdr[63:32], ecc 0, vld 1}; capture hdr[31:0]; beat_cnt <= req_nbeats; go to HDR1.
  - HDR1: output <= {hdr[31:0], 0, 0}. Go to DATA if beat_cnt!=0, else IDLE.
  - DATA: dat_pop=1 combinationally; output <= {dat_word, dat_ecc, 0}; beat_cnt decrements; leave for IDLE after the word with beat_cnt==1.
  - IDLE with no accept: outputs <= 0.
- Packet timing: one cycle from accept to first word on the bus. Packet length on the bus is 2 + nbeats cycles, contiguous. A back-to-back accept occurs at the earliest in the first IDLE cycle after the last word is launched.
- Credits:
  - On accept, iq_cnt decrements, and wib_cnt decrements if req_wr.
  - A dequeue pulse increments the matching counter.
  - Accept and dequeue in the same cycle leave the counter unchanged.
  - A dequeue arriving when the counter is at maximum holds the counter and sets credit_err; credit_err clears only on rst.
- POR: sctag_jbi_por_req_d1 blocks new accepts only; an in-flight packet always completes.
- Illegal req_nbeats values are treated as 16. Verification flags them with an assertion.
- Reset mid-packet: the packet is aborted immediately, outputs go to 0, and credits are restored to full.

Decomposition:
- Shared package jbi_sc2_pkg holds: FSM state encoding; beat constants NB_NONE=0, NB_8B=2, NB_64B=16; header/ECC widths.
- Sub-module jbi_credit_cnt is parameterized by depth. It is instantiated twice (IQ, WIB) and provides inc, dec, count, nonzero and overflow-error outputs.

Test Plan:
- Read (nbeats=0, hdr=64'hA5A5_0000_1234_5678) from reset → next cycles: bus 32'hA5A50000 with vld=1, then 32'h12345678 with vld=0; dat_pop never asserted; iq_credits 16→15.
- 64B write with 16 words 0..15 → 18 contiguous bus words; vld only on word 0; ECC equals dat_ecc on words 2..17; dat_pop high for exactly 16 cycles; wib_cnt 4→3.
- Issue 16 reads with no dequeue → req_rdy low on the 17th. A single iq_dequeue pulse raises req_rdy on the next cycle.
- Accept coincident with iq_dequeue → iq_credits unchanged; a dequeue at 16 credits → credit_err=1 and stays 1.
- por_req asserted during word 5 of a 64B write → packet completes all 18 words; no accept while por high; accepts resume one cycle after por falls.
- rst asserted mid-DATA → all outputs 0 asynchronously; iq_credits=16 after release; the next request issues normally.
